reg_writeback_ctrl: RTL and testbench

Write-side controller for the 7-entry register file (R0–R5 general, R6 = PC). Accepts results from the ALU and memory-load paths over valid/ready handshakes, buffers them in a 4-entry FIFO, and issues one registered write per cycle on the file's `Write_Enable`/`Write_addr`/`Data_in` port. It also owns the program counter: it keeps the PC register and drives the file's `new_pc_in`, so all R6 writes arrive as PC loads rather than port writes.

---
 rtl/reg_writeback_ctrl.sv | 98 +++++++++
 tb/tb_reg_writeback_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: 4-entry write-back FIFO from ALU/load paths to the register file, owns the PC.
// Define WB_R0_ZERO_EN to treat R0 as hardwired zero (addr-0 entries are silently discarded).
module reg_writeback_ctrl #(
  parameter int ADDR = 6,
  parameter int WORD = 16,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            alu_valid,
  input  logic [ADDR-1:0] alu_addr,
  input  logic [WORD-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [ADDR-1:0] mem_addr,
  input  logic [WORD-1:0] mem_data,
  output logic            mem_ready,
  input  logic            pc_step,
  output logic            Write_Enable,
  output logic [ADDR-1:0] Write_addr,
  output logic [WORD-1:0] Data_in,
  output logic [WORD-1:0] new_pc,
  output logic            busy,
  output logic            bad_addr
);
`ifdef WB_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif
  logic [ADDR-1:0] fa_q [4];
  logic [WORD-1:0] fd_q [4];
  logic [2:0] count_q, count_d;
  logic [1:0] wr_q, wr_d, rd_q, rd_d, alu_slot;
  logic we_q, we_d, bad_q, bad_d;
  logic [ADDR-1:0] wa_q, wa_d, head_a;
  logic [WORD-1:0] wd_q, wd_d, pc_q, pc_d, head_d;
  logic mem_acc, alu_acc, deq, wb, pc_ld;
  // Readiness uses the pre-dequeue count, so a full FIFO can never be enqueued into.
  assign mem_ready = Reset | (count_q != 3'd4);
  assign alu_ready = Reset | (count_q <= 3'd2) | ((count_q == 3'd3) & !mem_valid);
  assign mem_acc = mem_valid & mem_ready;
  assign alu_acc = alu_valid & alu_ready;
  assign head_a = fa_q[rd_q];
  assign head_d = fd_q[rd_q];
  assign Write_Enable = we_q;
  assign Write_addr = wa_q;
  assign Data_in = wd_q;
  assign new_pc = pc_q;
  assign bad_addr = bad_q;
  assign busy = (count_q != 3'd0) | we_q;
  always_comb begin
    deq = count_q != 3'd0;
    wb = deq && (head_a < ADDR'(6)) && !(R0_ZERO && head_a == '0);
    pc_ld = deq && (head_a == ADDR'(6));
    alu_slot = wr_q + {1'b0, mem_acc};
    wr_d = alu_slot + {1'b0, alu_acc};
    rd_d = rd_q + {1'b0, deq};
    count_d = count_q + {2'b0, mem_acc} + {2'b0, alu_acc} - {2'b0, deq};
    we_d = wb;
    wa_d = wb ? head_a : wa_q;
    wd_d = wb ? head_d : wd_q;
    bad_d = bad_q | (deq && (head_a > ADDR'(6)));
    pc_d = pc_ld ? head_d : pc_step ? pc_q + WORD'(1) : pc_q;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      bad_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      bad_q <= bad_d;
      pc_q <= pc_d;
    end
  end
  // Storage needs no reset: the count alone decides which slots are live.
  always_ff @(posedge Clk) begin
    if (mem_acc) begin
      fa_q[wr_q] <= mem_addr;
      fd_q[wr_q] <= mem_data;
    end
    if (alu_acc) begin
      fa_q[alu_slot] <= alu_addr;
      fd_q[alu_slot] <= alu_data;
    end
  end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed vector table plus contention, reset and pointer-wrap sequences.
module tb_reg_writeback_ctrl;
  logic Clk = 1'b0, Reset = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0, pc_step = 1'b0;
  logic [5:0] alu_addr = '0, mem_addr = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic alu_ready, mem_ready, Write_Enable, busy, bad_addr;
  logic [5:0] Write_addr;
  logic [15:0] Data_in, new_pc;
  int n_vec = 0, n_err = 0;

  reg_writeback_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .pc_step(pc_step), .Write_Enable(Write_Enable), .Write_addr(Write_addr), .Data_in(Data_in),
    .new_pc(new_pc), .busy(busy), .bad_addr(bad_addr)
  );

  initial forever #5 Clk = ~Clk;

`ifdef WB_R0_ZERO_EN
  localparam logic R0W = 1'b0;
  localparam logic [5:0] LA = 6'd3;
  localparam logic [15:0] LD = 16'h1234;
`else
  localparam logic R0W = 1'b1;
  localparam logic [5:0] LA = 6'd0;
  localparam logic [15:0] LD = 16'hBEEF;
`endif

  typedef struct {
    logic av; logic [5:0] aa; logic [15:0] ad;
    logic mv; logic [5:0] ma; logic [15:0] md;
    logic st; logic ar; logic mr;
    logic we; logic [5:0] wa; logic [15:0] di; logic [15:0] pc; logic bsy; logic bad;
  } vec_t;
  vec_t tbl[20];
  logic [21:0] got[$];
  logic [21:0] exp_c[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (Write_Enable) got.push_back({Write_addr, Data_in});
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; pc_step = 0;
  endtask

  task automatic chk_outs(input string nm, input logic we, input logic [5:0] wa, input logic [15:0] di,
                          input logic [15:0] pc, input logic bsy, input logic bad);
    chk({nm, ".we"}, Write_Enable, we);
    chk({nm, ".waddr"}, Write_addr, wa);
    chk({nm, ".din"}, Data_in, di);
    chk({nm, ".pc"}, new_pc, pc);
    chk({nm, ".busy"}, busy, bsy);
    chk({nm, ".bad"}, bad_addr, bad);
  endtask

  initial begin
    //          av aa   ad        mv ma   md        st ar mr we   wa     di         pc         bsy  bad
    tbl[0]  = '{1, 6'd3, 16'h1234, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   6'd0, 16'h0000, 16'h0000, 1,   0};
    tbl[1]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 1,   6'd3, 16'h1234, 16'h0000, 1,   0};
    tbl[2]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   6'd3, 16'h1234, 16'h0000, 0,   0};
    tbl[3]  = '{1, 6'd6, 16'h0100, 0, 6'd0, 16'h0000, 1, 1, 1, 0,   6'd3, 16'h1234, 16'h0001, 1,   0};
    tbl[4]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 1, 1, 1, 0,   6'd3, 16'h1234, 16'h0100, 0,   0};
    tbl[5]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 1, 1, 1, 0,   6'd3, 16'h1234, 16'h0101, 0,   0};
    tbl[6]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 1, 1, 1, 0,   6'd3, 16'h1234, 16'h0102, 0,   0};
    tbl[7]  = '{1, 6'd0, 16'hBEEF, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   6'd3, 16'h1234, 16'h0102, 1,   0};
    tbl[8]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, R0W, LA,   LD,       16'h0102, R0W, 0};
    tbl[9]  = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   LA,   LD,       16'h0102, 0,   0};
    tbl[10] = '{0, 6'd0, 16'h0000, 1, 6'd9, 16'hDEAD, 0, 1, 1, 0,   LA,   LD,       16'h0102, 1,   0};
    tbl[11] = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   LA,   LD,       16'h0102, 0,   1};
    tbl[12] = '{1, 6'd6, 16'hFFFE, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   LA,   LD,       16'h0102, 1,   1};
    tbl[13] = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   LA,   LD,       16'hFFFE, 0,   1};
    tbl[14] = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 1, 1, 1, 0,   LA,   LD,       16'hFFFF, 0,   1};
    tbl[15] = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 1, 1, 1, 0,   LA,   LD,       16'h0000, 0,   1};
    tbl[16] = '{1, 6'd5, 16'h5555, 1, 6'd4, 16'h4444, 0, 1, 1, 0,   LA,   LD,       16'h0000, 1,   1};
    tbl[17] = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 1,   6'd4, 16'h4444, 16'h0000, 1,   1};
    tbl[18] = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 1,   6'd5, 16'h5555, 16'h0000, 1,   1};
    tbl[19] = '{0, 6'd0, 16'h0000, 0, 6'd0, 16'h0000, 0, 1, 1, 0,   6'd5, 16'h5555, 16'h0000, 0,   1};
    exp_c[0] = {6'd1, 16'hAA00}; exp_c[1] = {6'd2, 16'h5500}; exp_c[2] = {6'd1, 16'hAA01};
    exp_c[3] = {6'd2, 16'h5501}; exp_c[4] = {6'd1, 16'hAA02}; exp_c[5] = {6'd1, 16'hAA03};
    exp_c[6] = {6'd2, 16'h5504};

    repeat (2) @(posedge Clk);
    #1;
    chk_outs("por", 0, 6'd0, 16'h0000, 16'h0000, 0, 0);
    chk("por.alu_ready", alu_ready, 1);
    chk("por.mem_ready", mem_ready, 1);
    #2 Reset = 0;

    for (int i = 0; i < 20; i++) begin
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
      pc_step = tbl[i].st;
      #1;
      chk($sformatf("v%0d.alu_ready", i), alu_ready, tbl[i].ar);
      chk($sformatf("v%0d.mem_ready", i), mem_ready, tbl[i].mr);
      @(posedge Clk);
      #1;
      chk_outs($sformatf("v%0d", i), tbl[i].we, tbl[i].wa, tbl[i].di, tbl[i].pc, tbl[i].bsy, tbl[i].bad);
    end

    // Contention: mem takes the last free slot, ALU waits until mem goes idle.
    got.delete();
    mem_addr = 6'd1; alu_addr = 6'd2;
    for (int k = 0; k < 5; k++) begin
      mem_valid = (k < 4); alu_valid = 1;
      mem_data = 16'hAA00 + 16'(k); alu_data = 16'h5500 + 16'(k);
      #1;
      chk($sformatf("cont%0d.alu_ready", k), alu_ready, (k < 2 || k == 4));
      chk($sformatf("cont%0d.mem_ready", k), mem_ready, 1);
      tick();
    end
    idle();
    repeat (8) tick();
    chk("cont.nwrites", got.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("cont.w%0d", i), i < got.size() ? got[i] : 22'h3FFFFF, exp_c[i]);

    // Asynchronous reset mid-cycle with three entries queued.
    pc_step = 1;
    repeat (3) tick();
    pc_step = 0;
    chk("rst.pc_pre", new_pc, 16'h0003);
    mem_valid = 1; mem_addr = 6'd1; mem_data = 16'h0111;
    alu_valid = 1; alu_addr = 6'd2; alu_data = 16'h0222;
    tick();
    mem_data = 16'h0333; alu_data = 16'h0444;
    tick();
    idle();
    chk("rst.busy_pre", busy, 1);
    #2 Reset = 1;
    #1;
    chk_outs("rst", 0, 6'd0, 16'h0000, 16'h0000, 0, 0);
    chk("rst.alu_ready", alu_ready, 1);
    chk("rst.mem_ready", mem_ready, 1);
    @(posedge Clk);
    #3 Reset = 0;
    got.delete();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst_post%0d.we", k), Write_Enable, 0);
      chk($sformatf("rst_post%0d.busy", k), busy, 0);
    end
    chk("rst_post.pc", new_pc, 16'h0000);

    // Ten back-to-back entries walk the pointers round the ring more than twice.
    got.delete();
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1; alu_addr = 6'(1 + i % 5); alu_data = 16'h1000 + 16'(i);
      tick();
    end
    idle();
    repeat (4) tick();
    chk("wrap.nwrites", got.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("wrap.w%0d", i), i < got.size() ? got[i] : 22'h3FFFFF,
          {6'(1 + i % 5), 16'h1000 + 16'(i)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
